// File: rtl/board_io_pkg.sv
// Shared constants, cycle-count helper and types for the board input front end.
package board_io_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned DEBOUNCE_MS   = 10;
    localparam int unsigned LONG_PRESS_MS = 1000;

    typedef logic [7:0] press_cnt_t;

    // Accepted level of a debounced channel.
    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } deb_state_t;

    // Divide first so long durations stay inside 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a counting
// debounce FSM. rise/fall are registered together with the accepted level.
module debounce_ch
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_d, fall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = (state_q == LVL_HIGH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LVL_LOW;
            cnt_q   <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Any sample agreeing with the accepted level restarts the stability count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced != level) begin
            if (cnt_q == CNT_LAST) begin
                state_d = (state_q == LVL_HIGH) ? LVL_LOW : LVL_HIGH;
                rise_d  = (state_q == LVL_LOW);
                fall_d  = (state_q == LVL_HIGH);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/board_input_conditioner.sv
// Debounced buttons/switches with press, release and long-press events.
// Optional BOARD_INPUT_PRESS_COUNT_EN adds an 8-bit wrapping press counter per button.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int NUM_BTN           = 4,
    parameter int NUM_SW            = 16,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = int'(ms_to_cycles(DEBOUNCE_MS)),
    parameter int LONG_PRESS_CYCLES = int'(ms_to_cycles(LONG_PRESS_MS))
) (
    input  logic               clk_100mhz,
    input  logic               sys_rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_SW-1:0]  sw_level,
    output logic               sw_changed
`ifdef BOARD_INPUT_PRESS_COUNT_EN
    ,
    output logic [NUM_BTN*8-1:0] btn_count
`endif
);

    localparam int NUM_CH = NUM_BTN + NUM_SW;
    localparam int HW     = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [NUM_CH-1:0] ch_raw, ch_level, ch_rise, ch_fall;

    // Buttons occupy the low channel indices, switches the upper ones.
    assign ch_raw = {sw_raw, btn_raw};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            debounce_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk  (clk_100mhz),
                .rst  (sys_rst),
                .raw  (ch_raw[g]),
                .level(ch_level[g]),
                .rise (ch_rise[g]),
                .fall (ch_fall[g])
            );
        end
    endgenerate

    assign btn_level   = ch_level[NUM_BTN-1:0];
    assign btn_press   = ch_rise[NUM_BTN-1:0];
    assign btn_release = ch_fall[NUM_BTN-1:0];
    assign sw_level    = ch_level[NUM_CH-1:NUM_BTN];
    assign sw_changed  = |(ch_rise[NUM_CH-1:NUM_BTN] | ch_fall[NUM_CH-1:NUM_BTN]);

    logic [NUM_BTN-1:0][HW-1:0] hold_cnt;

    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_hold
            logic long_q;

            // Saturation at HOLD_MAX is what limits btn_long to one pulse per press.
            always_ff @(posedge clk_100mhz or posedge sys_rst) begin
                if (sys_rst) begin
                    hold_cnt[g] <= '0;
                    long_q      <= 1'b0;
                end else begin
                    long_q <= btn_level[g] && (hold_cnt[g] == HOLD_LAST);
                    if (!btn_level[g])
                        hold_cnt[g] <= '0;
                    else if (hold_cnt[g] != HOLD_MAX)
                        hold_cnt[g] <= hold_cnt[g] + HW'(1);
                end
            end

            assign btn_long[g] = long_q;
        end
    endgenerate

`ifdef BOARD_INPUT_PRESS_COUNT_EN
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_cnt
            press_cnt_t cnt_q;

            always_ff @(posedge clk_100mhz or posedge sys_rst) begin
                if (sys_rst)           cnt_q <= '0;
                else if (btn_press[g]) cnt_q <= cnt_q + 8'd1;
            end

            assign btn_count[g*8 +: 8] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench: window-based reference model pushes per-cycle expectations,
// a negedge monitor pops and compares; directed phases check event timing.
module tb_board_input_conditioner;

    localparam int NB  = 4;
    localparam int NS  = 16;
    localparam int SS  = 2;
    localparam int DC  = 4;
    localparam int LP  = 10;
    localparam int NCH = NB + NS;

    logic          clk_100mhz = 1'b0;
    logic          sys_rst;
    logic [NB-1:0] btn_raw;
    logic [NS-1:0] sw_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;
    logic [NS-1:0] sw_level;
    logic          sw_changed;
    logic [NB*8-1:0] cnt_out;
`ifdef BOARD_INPUT_PRESS_COUNT_EN
    logic [NB*8-1:0] btn_count;
    assign cnt_out = btn_count;
`else
    assign cnt_out = '0;
`endif

    always #5 clk_100mhz = ~clk_100mhz;

    board_input_conditioner #(
        .NUM_BTN(NB), .NUM_SW(NS), .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .sys_rst    (sys_rst),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .sw_level   (sw_level),
        .sw_changed (sw_changed)
`ifdef BOARD_INPUT_PRESS_COUNT_EN
        ,
        .btn_count  (btn_count)
`endif
    );

    typedef struct packed {
        logic [NB-1:0]   lvl;
        logic [NB-1:0]   press;
        logic [NB-1:0]   rel;
        logic [NB-1:0]   lng;
        logic [NS-1:0]   swl;
        logic            swch;
        logic [NB*8-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int npress[NB], nrel[NB], nlong[NB];
    int last_press[NB], last_rel[NB], last_long[NB];
    int nswch = 0, last_swch = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, expv);
        end
    endtask

    // Reference model: a level flips once the last DC synced samples all disagree with it.
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_lvl;
    logic [NB-1:0]  m_prev_press;
    int             m_held[NB];
    int             m_cnt[NB];

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < SS + DC; i++) hist.push_back('0);
        m_lvl        = '0;
        m_prev_press = '0;
        for (int b = 0; b < NB; b++) begin
            m_held[b] = 0;
            m_cnt[b]  = 0;
        end
    endtask

    initial begin
        exp_t           e;
        logic [NCH-1:0] old, flip, smp;
        model_clear();
        forever begin
            @(posedge clk_100mhz);
            cyc++;
            e = '0;
            if (sys_rst) begin
                model_clear();
            end else begin
                old = m_lvl;
                hist.push_back({sw_raw, btn_raw});
                for (int ch = 0; ch < NCH; ch++) begin
                    flip[ch] = 1'b1;
                    for (int j = 0; j < DC; j++) begin
                        smp = hist[hist.size() - 1 - SS - j];
                        if (smp[ch] == old[ch]) flip[ch] = 1'b0;
                    end
                end
                while (hist.size() > SS + DC + 4) void'(hist.pop_front());
                m_lvl = old ^ flip;
                for (int b = 0; b < NB; b++) begin
                    e.lng[b] = old[b] && (m_held[b] == LP - 1);
                    m_held[b] = old[b] ? ((m_held[b] < LP) ? m_held[b] + 1 : LP) : 0;
                    if (m_prev_press[b]) m_cnt[b] = (m_cnt[b] + 1) % 256;
                    e.cnt[b*8 +: 8] = 8'(m_cnt[b]);
                end
                e.lvl        = m_lvl[NB-1:0];
                e.press      = flip[NB-1:0] & ~old[NB-1:0];
                e.rel        = flip[NB-1:0] & old[NB-1:0];
                e.swl        = m_lvl[NCH-1:NB];
                e.swch       = |flip[NCH-1:NB];
                m_prev_press = e.press;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every cycle; any reset-high sample must read all zero.
    initial begin
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            npress[b] = 0; nrel[b] = 0; nlong[b] = 0;
            last_press[b] = -1; last_rel[b] = -1; last_long[b] = -1;
        end
        forever begin
            @(negedge clk_100mhz);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            if (sys_rst) e = '0;
            chk("btn_level",   64'(btn_level),   64'(e.lvl));
            chk("btn_press",   64'(btn_press),   64'(e.press));
            chk("btn_release", 64'(btn_release), 64'(e.rel));
            chk("btn_long",    64'(btn_long),    64'(e.lng));
            chk("sw_level",    64'(sw_level),    64'(e.swl));
            chk("sw_changed",  64'(sw_changed),  64'(e.swch));
`ifdef BOARD_INPUT_PRESS_COUNT_EN
            chk("btn_count",   64'(cnt_out),     64'(e.cnt));
`endif
            for (int b = 0; b < NB; b++) begin
                if (btn_press[b])   begin npress[b]++; last_press[b] = cyc; end
                if (btn_release[b]) begin nrel[b]++;   last_rel[b]   = cyc; end
                if (btn_long[b])    begin nlong[b]++;  last_long[b]  = cyc; end
            end
            if (sw_changed) begin nswch++; last_swch = cyc; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100mhz);
        #2;
    endtask

    initial begin
        int c0, p, r, l, s;
        sys_rst = 1'b1;
        btn_raw = '1;
        sw_raw  = '0;
        tick(3);
        sys_rst = 1'b0;
        btn_raw = '0;
        tick(12);

        // clean step on btn[1]
        c0 = cyc; p = npress[1];
        btn_raw[1] = 1'b1;
        tick(12);
        chk("step_press_n",   64'(npress[1] - p), 64'd1);
        chk("step_press_cyc", 64'(last_press[1]), 64'(c0 + 6));
        btn_raw[1] = 1'b0;
        tick(12);

        // 3-cycle glitch on btn[2]
        p = npress[2]; r = nrel[2];
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[2] = 1'b0;
        tick(12);
        chk("glitch_press", 64'(npress[2] - p), 64'd0);
        chk("glitch_rel",   64'(nrel[2] - r),   64'd0);

        // bouncing sw[5]
        s = nswch;
        for (int i = 0; i < 4; i++) begin
            sw_raw[5] = (i % 2 == 0);
            tick(2);
        end
        sw_raw[5] = 1'b1;
        c0 = cyc;
        tick(14);
        chk("bounce_swch_n",   64'(nswch - s), 64'd1);
        chk("bounce_swch_cyc", 64'(last_swch), 64'(c0 + 6));
        sw_raw[5] = 1'b0;
        tick(12);

        // long press on btn[0], 30 cycles
        c0 = cyc; l = nlong[0]; r = nrel[0];
        btn_raw[0] = 1'b1;
        tick(30);
        btn_raw[0] = 1'b0;
        tick(12);
        chk("long_press_cyc", 64'(last_press[0]), 64'(c0 + 6));
        chk("long_n",         64'(nlong[0] - l),  64'd1);
        chk("long_cyc",       64'(last_long[0]),  64'(c0 + 16));
        chk("long_rel_n",     64'(nrel[0] - r),   64'd1);
        chk("long_rel_cyc",   64'(last_rel[0]),   64'(c0 + 36));

        // short hold: no long pulse
        l = nlong[0]; p = npress[0];
        btn_raw[0] = 1'b1;
        tick(8);
        btn_raw[0] = 1'b0;
        tick(12);
        chk("short_press_n", 64'(npress[0] - p), 64'd1);
        chk("short_long_n",  64'(nlong[0] - l),  64'd0);

        // random traffic: glitches, holds and simultaneous events
        for (int it = 0; it < 200; it++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(3) == 0) btn_raw[b] = ~btn_raw[b];
            for (int w = 0; w < NS; w++)
                if ($urandom_range(5) == 0) sw_raw[w] = ~sw_raw[w];
            tick($urandom_range(1, 9));
        end

        // asynchronous reset mid-cycle with inputs held high
        btn_raw = 4'b0001;
        sw_raw  = 16'h00A0;
        tick(20);
        #1 sys_rst = 1'b1;
        #1 chk("async_rst", 64'({btn_level, btn_press, btn_release, btn_long, sw_level, sw_changed}), 64'd0);
        tick(2);
        p = npress[0]; s = nswch;
        sys_rst = 1'b0;
        tick(20);
        chk("rst_repress_n", 64'(npress[0] - p), 64'd1);
        chk("rst_swch_n",    64'(nswch - s),     64'd1);

`ifdef BOARD_INPUT_PRESS_COUNT_EN
        btn_raw = '0;
        sw_raw  = '0;
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(8);
        for (int i = 0; i < 257; i++) begin
            btn_raw[3] = 1'b1;
            tick(6);
            btn_raw[3] = 1'b0;
            tick(6);
        end
        tick(8);
        chk("count_btn3",   64'(btn_count[31:24]), 64'd1);
        chk("count_others", 64'(btn_count[23:0]),  64'd0);
`endif

        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
